mlp_load_receiver: RTL and testbench
====================================

// Module: mlp_load_receiver
// PURPOSE
//  Receiving end of the MLP_acc_top load interface. Decodes the host beat stream
//  (load_en_i/load_type_i/load_payload_i plus row, layer and weight indices).
//  Assembles each 16-element activation row from 8 input beats, forwards weight-pair
//  beats to the PE array, and signals row/layer completion and protocol errors.
//  Sits between the MLP_acc_top ports and the activation/weight buffers.
// PARAMETERS
//  DATA_W     16  width of one activation/weight element
//  ROW_ELEMS  16  elements per activation row (input beats per row = ROW_ELEMS/2 = 8)
//  W_BEATS     8  weight beats per row (weight_number 0..7)
// PORTS
//  clk                input   1    system clock, all state on rising edge
//  rst_n              input   1    asynchronous active-low reset
//  load_en_i          input   1    beat valid; a beat is accepted on any edge with load_en_i=1
//  load_payload_i     input   32   {elem_hi, elem_lo}, two DATA_W elements
//  load_type_i        input   1    1 = input (activation) beat, 0 = weight beat
//  input_load_number  input   4    row index 0-15 of the current beat
//  layer_number       input   3    layer 0-7 of the current beat
//  weight_number      input   3    weight pair index 0-7 (weight beats only)
//  err_clr_i          input   1    clears err_o
//  act_row_o          output  256  assembled row; element k at [16k +: 16]
//  act_row_valid_o    output  1    1-cycle pulse, act_row_o complete
//  act_row_idx_o      output  4    row index of act_row_o
//  w_valid_o          output  1    1-cycle pulse per accepted weight beat
//  w_pair_o           output  32   weight payload; [15:0]=W[2w][row], [31:16]=W[2w+1][row]
//  w_row_o            output  4    row index of w_pair_o
//  w_col_pair_o       output  3    weight_number of w_pair_o
//  w_layer_o          output  3    layer of w_pair_o
//  layer_done_o       output  1    1-cycle pulse: row 15, weight_number 7 accepted
//  layer_done_num_o   output  3    layer that finished
//  err_o              output  3    sticky protocol error flags
// BEHAVIOUR
//  - Reset: every output and internal register is 0; FSM = IDLE; partial row discarded.
//  - FSM: IDLE, IN_ROW, W_ROW. The type of the accepted beat selects the next state.
//    A type=1 beat goes to IN_ROW. A type=0 beat goes to W_ROW.
//    With load_en_i=0 the FSM holds state, counters and buffers. Stalls of any length are legal.
//  - Input beat: in_cnt (0-7) selects the slot. payload[15:0] goes to element 2*in_cnt;
//    payload[31:16] goes to element 2*in_cnt+1. Beat 0 latches input_load_number as row_lat.
//  - On the 8th input beat (in_cnt=7), in_cnt wraps to 0.
//    On the next cycle: act_row_valid_o=1, act_row_o holds all 16 elements, act_row_idx_o=row_lat.
//    act_row_o holds until the next row completes.
//  - Weight beat: registered pass-through with 1-cycle latency. w_valid_o=1 with payload,
//    input_load_number, weight_number and layer_number. exp_w tracks the expected index
//    and wraps 7->0. Weight beats with no preceding input row are legal (layers 1-7).
//  - layer_done_o/layer_done_num_o: pulse in the same cycle as w_valid_o for the beat
//    with input_load_number=15 and weight_number=7.
//  - err_o bits are sticky and set 1 cycle after the offending beat:
//      [0] weight beat while in_cnt!=0. The partial row is discarded, in_cnt is set to 0,
//          and the beat is still forwarded as a weight beat.
//      [1] weight_number != exp_w. The beat is forwarded and exp_w resyncs to weight_number+1.
//      [2] input_load_number != row_lat on input beats 1-7. The row still completes.
//  - err_clr_i zeroes err_o. If err_clr_i coincides with a new error, the new error bit ends set.
//  - Async reset mid-row: outputs drop to 0 immediately. The next input beat is element slot 0.
// TESTING
//  1 Assert rst_n=0 mid-stream -> all outputs 0 at once; after release, no pulses without beats.
//  2 Layer 0, row 3, 8 input beats with payload {2k+1,2k} for k=0..7
//    -> one cycle after beat 8: act_row_valid_o=1, act_row_idx_o=3, act_row_o[16k+:16]=k.
//  3 Then 8 weight beats with w=0..7, payload 0xA000_0000+w -> w_valid_o for 8 consecutive cycles,
//    w_col_pair_o=0..7, w_row_o=3, err_o=0.
//  4 Full layer 1 (16 rows x 8 weight beats, no input beats) -> 128 w_valid_o,
//    one layer_done_o with layer_done_num_o=1, 0 act_row_valid_o.
//  5 load_en_i=0 for 3 cycles between input beats 3 and 4 -> row identical to test 2, one valid pulse.
//  6 Weight beat after input beat 4 -> err_o=3'b001 and no act_row_valid_o.
//    Weight sequence 0,2 -> err_o[1] set. err_clr_i -> err_o=0.

Source files
------------

// File: rtl/mlp_load_receiver.sv
// mlp_load_receiver: decodes the host load beat stream, assembles activation rows,
// forwards weight-pair beats and flags protocol errors. Rev 1.0
`default_nettype none

module mlp_load_receiver #(
  parameter int DATA_W    = 16,
  parameter int ROW_ELEMS = 16,
  parameter int W_BEATS   = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        load_en_i,
  input  logic [2*DATA_W-1:0]         load_payload_i,
  input  logic                        load_type_i,
  input  logic [3:0]                  input_load_number,
  input  logic [2:0]                  layer_number,
  input  logic [2:0]                  weight_number,
  input  logic                        err_clr_i,
  output logic [ROW_ELEMS*DATA_W-1:0] act_row_o,
  output logic                        act_row_valid_o,
  output logic [3:0]                  act_row_idx_o,
  output logic                        w_valid_o,
  output logic [2*DATA_W-1:0]         w_pair_o,
  output logic [3:0]                  w_row_o,
  output logic [2:0]                  w_col_pair_o,
  output logic [2:0]                  w_layer_o,
  output logic                        layer_done_o,
  output logic [2:0]                  layer_done_num_o,
  output logic [2:0]                  err_o
);

  localparam int IN_BEATS = ROW_ELEMS / 2;
  localparam int CNT_W    = $clog2(IN_BEATS);
  localparam int ROW_W    = ROW_ELEMS * DATA_W;
  localparam int BEAT_W   = 2 * DATA_W;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_IN_ROW = 2'd1,
    S_W_ROW  = 2'd2
  } state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    in_cnt_q;
  logic [3:0]          row_lat_q;
  logic [2:0]          exp_w_q;
  logic [ROW_W-1:0]    row_buf_q;
  logic [ROW_W-1:0]    act_row_q;
  logic                act_row_valid_q;
  logic [3:0]          act_row_idx_q;
  logic                w_valid_q;
  logic [BEAT_W-1:0]   w_pair_q;
  logic [3:0]          w_row_q;
  logic [2:0]          w_col_pair_q;
  logic [2:0]          w_layer_q;
  logic                layer_done_q;
  logic [2:0]          layer_done_num_q;
  logic [2:0]          err_q;

  logic [ROW_W-1:0]    row_d;
  logic [2:0]          err_new_d;
  logic [2:0]          exp_w_d;
  logic                in_last_d;
  logic                last_w_d;
  logic                last_row_d;

  always_comb begin
    row_d = row_buf_q;
    row_d[32'(in_cnt_q) * BEAT_W +: BEAT_W] = load_payload_i;
    in_last_d  = (in_cnt_q == CNT_W'(IN_BEATS - 1));
    last_w_d   = (weight_number == 3'(W_BEATS - 1));
    last_row_d = (input_load_number == 4'(ROW_ELEMS - 1));
    exp_w_d    = last_w_d ? 3'd0 : weight_number + 3'd1;
    err_new_d  = 3'b000;
    if (load_en_i) begin
      if (load_type_i) begin
        err_new_d[2] = (in_cnt_q != '0) && (input_load_number != row_lat_q);
      end else begin
        // A partial row can only exist while assembling input beats.
        err_new_d[0] = (state_q == S_IN_ROW) && (in_cnt_q != '0);
        err_new_d[1] = (weight_number != exp_w_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      in_cnt_q         <= '0;
      row_lat_q        <= '0;
      exp_w_q          <= '0;
      row_buf_q        <= '0;
      act_row_q        <= '0;
      act_row_valid_q  <= 1'b0;
      act_row_idx_q    <= '0;
      w_valid_q        <= 1'b0;
      w_pair_q         <= '0;
      w_row_q          <= '0;
      w_col_pair_q     <= '0;
      w_layer_q        <= '0;
      layer_done_q     <= 1'b0;
      layer_done_num_q <= '0;
      err_q            <= '0;
    end else begin
      act_row_valid_q <= 1'b0;
      w_valid_q       <= 1'b0;
      layer_done_q    <= 1'b0;
      // Clear first so an error arriving with the clear still ends set.
      err_q <= (err_clr_i ? 3'b000 : err_q) | err_new_d;
      if (load_en_i) begin
        if (load_type_i) begin
          state_q   <= S_IN_ROW;
          row_buf_q <= row_d;
          if (in_cnt_q == '0) begin
            row_lat_q <= input_load_number;
          end
          if (in_last_d) begin
            in_cnt_q        <= '0;
            act_row_q       <= row_d;
            act_row_valid_q <= 1'b1;
            act_row_idx_q   <= row_lat_q;
          end else begin
            in_cnt_q <= in_cnt_q + CNT_W'(1);
          end
        end else begin
          state_q      <= S_W_ROW;
          in_cnt_q     <= '0;
          exp_w_q      <= exp_w_d;
          w_valid_q    <= 1'b1;
          w_pair_q     <= load_payload_i;
          w_row_q      <= input_load_number;
          w_col_pair_q <= weight_number;
          w_layer_q    <= layer_number;
          if (last_row_d && last_w_d) begin
            layer_done_q     <= 1'b1;
            layer_done_num_q <= layer_number;
          end
        end
      end
    end
  end

  assign act_row_o        = act_row_q;
  assign act_row_valid_o  = act_row_valid_q;
  assign act_row_idx_o    = act_row_idx_q;
  assign w_valid_o        = w_valid_q;
  assign w_pair_o         = w_pair_q;
  assign w_row_o          = w_row_q;
  assign w_col_pair_o     = w_col_pair_q;
  assign w_layer_o        = w_layer_q;
  assign layer_done_o     = layer_done_q;
  assign layer_done_num_o = layer_done_num_q;
  assign err_o            = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mlp_load_receiver.sv
// +----------------------------------------------------------------------+
// | Module : tb_mlp_load_receiver                                        |
// | Brief  : directed self-checking bench for mlp_load_receiver          |
// | Rev    : 1.1                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_mlp_load_receiver;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         load_en_i;
    logic [31:0]  load_payload_i;
    logic         load_type_i;
    logic [3:0]   input_load_number;
    logic [2:0]   layer_number;
    logic [2:0]   weight_number;
    logic         err_clr_i;
    logic [255:0] act_row_o;
    logic         act_row_valid_o;
    logic [3:0]   act_row_idx_o;
    logic         w_valid_o;
    logic [31:0]  w_pair_o;
    logic [3:0]   w_row_o;
    logic [2:0]   w_col_pair_o;
    logic [2:0]   w_layer_o;
    logic         layer_done_o;
    logic [2:0]   layer_done_num_o;
    logic [2:0]   err_o;

    int tests = 0;
    int fails = 0;
    int n_act = 0;
    int n_w   = 0;
    int n_ld  = 0;

    logic [255:0] exp_row;
    int a0, w0, l0;

    mlp_load_receiver dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .load_en_i         (load_en_i),
        .load_payload_i    (load_payload_i),
        .load_type_i       (load_type_i),
        .input_load_number (input_load_number),
        .layer_number      (layer_number),
        .weight_number     (weight_number),
        .err_clr_i         (err_clr_i),
        .act_row_o         (act_row_o),
        .act_row_valid_o   (act_row_valid_o),
        .act_row_idx_o     (act_row_idx_o),
        .w_valid_o         (w_valid_o),
        .w_pair_o          (w_pair_o),
        .w_row_o           (w_row_o),
        .w_col_pair_o      (w_col_pair_o),
        .w_layer_o         (w_layer_o),
        .layer_done_o      (layer_done_o),
        .layer_done_num_o  (layer_done_num_o),
        .err_o             (err_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (act_row_valid_o) n_act++;
        if (w_valid_o)       n_w++;
        if (layer_done_o)    n_ld++;
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
        tests++;
        if (obs !== exp_v) begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        load_en_i = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic in_beat(input logic [3:0] row, input int k);
        load_en_i         = 1'b1;
        load_type_i       = 1'b1;
        input_load_number = row;
        layer_number      = 3'd0;
        load_payload_i    = {16'(2*k+1), 16'(2*k)};
        step();
        load_en_i = 1'b0;
    endtask

    task automatic w_beat(input logic [3:0] row, input logic [2:0] layer,
                          input logic [2:0] w, input logic [31:0] pl);
        load_en_i         = 1'b1;
        load_type_i       = 1'b0;
        input_load_number = row;
        layer_number      = layer;
        weight_number     = w;
        load_payload_i    = pl;
        step();
        load_en_i = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; load_en_i = 1'b0; load_type_i = 1'b0; load_payload_i = '0;
        input_load_number = '0; layer_number = '0; weight_number = '0; err_clr_i = 1'b0;
        for (int k = 0; k < 16; k++) exp_row[16*k +: 16] = 16'(k);
        step(); step();
        chk("reset_row", act_row_o, 256'd0);
        chk("reset_err", 256'(err_o), 256'd0);
        chk("reset_wpair", 256'(w_pair_o), 256'd0);
        rst_n = 1'b1;
        idle(3);
        chk("idle_no_pulses", 256'(n_act + n_w + n_ld), 256'd0);

        a0 = n_act;
        for (int k = 0; k < 8; k++) in_beat(4'd3, k);
        chk("row_valid", 256'(act_row_valid_o), 256'd1);
        chk("row_idx", 256'(act_row_idx_o), 256'd3);
        chk("row_data", act_row_o, exp_row);

        for (int w = 0; w < 8; w++) begin
            w_beat(4'd3, 3'd0, 3'(w), 32'hA000_0000 + 32'(w));
            chk("w_valid", 256'(w_valid_o), 256'd1);
            chk("w_col", 256'(w_col_pair_o), 256'(w));
            chk("w_row", 256'(w_row_o), 256'd3);
            chk("w_pair", 256'(w_pair_o), 256'(32'hA000_0000 + 32'(w)));
        end
        idle(1);
        chk("w_pulse_end", 256'(w_valid_o), 256'd0);
        chk("w_err", 256'(err_o), 256'd0);
        chk("row_pulse_once", 256'(n_act - a0), 256'd1);
        chk("row_hold", act_row_o, exp_row);

        a0 = n_act; w0 = n_w; l0 = n_ld;
        for (int r = 0; r < 16; r++) begin
            for (int w = 0; w < 8; w++) begin
                w_beat(4'(r), 3'd1, 3'(w), {16'(r), 16'(w)});
                if (r == 15 && w == 7) begin
                    chk("layer_done", 256'(layer_done_o), 256'd1);
                    chk("layer_done_num", 256'(layer_done_num_o), 256'd1);
                    chk("layer_w_layer", 256'(w_layer_o), 256'd1);
                end
            end
        end
        idle(1);
        chk("layer_w_count", 256'(n_w - w0), 256'd128);
        chk("layer_done_count", 256'(n_ld - l0), 256'd1);
        chk("layer_act_count", 256'(n_act - a0), 256'd0);
        chk("layer_err", 256'(err_o), 256'd0);

        for (int k = 0; k < 3; k++) in_beat(4'd9, k);
        rst_n = 1'b0;
        #1;
        chk("arst_row", act_row_o, 256'd0);
        chk("arst_idx", 256'(act_row_idx_o), 256'd0);
        chk("arst_wrow", 256'(w_row_o), 256'd0);
        chk("arst_wcol", 256'(w_col_pair_o), 256'd0);
        chk("arst_wlayer", 256'(w_layer_o), 256'd0);
        chk("arst_ldnum", 256'(layer_done_num_o), 256'd0);
        #2;
        rst_n = 1'b1;
        a0 = n_act; w0 = n_w; l0 = n_ld;
        idle(5);
        chk("arst_no_pulses", 256'((n_act - a0) + (n_w - w0) + (n_ld - l0)), 256'd0);

        a0 = n_act;
        for (int k = 0; k < 4; k++) in_beat(4'd3, k);
        idle(3);
        for (int k = 4; k < 8; k++) in_beat(4'd3, k);
        chk("stall_valid", 256'(act_row_valid_o), 256'd1);
        chk("stall_row", act_row_o, exp_row);
        chk("stall_idx", 256'(act_row_idx_o), 256'd3);
        idle(1);
        chk("stall_one_pulse", 256'(n_act - a0), 256'd1);

        a0 = n_act;
        for (int k = 0; k < 4; k++) in_beat(4'd2, k);
        w_beat(4'd2, 3'd0, 3'd0, 32'h1234_5678);
        chk("err0_set", 256'(err_o), 256'b001);
        chk("err0_fwd", 256'(w_valid_o), 256'd1);
        chk("err0_pair", 256'(w_pair_o), 256'h1234_5678);
        idle(2);
        chk("err0_no_row", 256'(n_act - a0), 256'd0);

        w_beat(4'd2, 3'd0, 3'd2, 32'h0000_0002);
        chk("err1_set", 256'(err_o), 256'b011);
        err_clr_i = 1'b1;
        idle(1);
        err_clr_i = 1'b0;
        chk("err_clr", 256'(err_o), 256'b000);

        err_clr_i = 1'b1;
        w_beat(4'd2, 3'd0, 3'd5, 32'h0000_0005);
        err_clr_i = 1'b0;
        chk("err_clr_collide", 256'(err_o), 256'b010);
        err_clr_i = 1'b1;
        idle(1);
        err_clr_i = 1'b0;
        chk("err_clr2", 256'(err_o), 256'b000);

        a0 = n_act;
        in_beat(4'd7, 0);
        chk("err2_clear_b0", 256'(err_o), 256'b000);
        in_beat(4'd8, 1);
        chk("err2_set", 256'(err_o), 256'b100);
        for (int k = 2; k < 8; k++) in_beat(4'd7, k);
        chk("err2_row_valid", 256'(act_row_valid_o), 256'd1);
        chk("err2_row_idx", 256'(act_row_idx_o), 256'd7);
        chk("err2_row_data", act_row_o, exp_row);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
